axil_slave_regfile: RTL and testbench
=====================================

Name: axil_slave_regfile

Overview:
AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers. It is the slave endpoint the AXI-Lite protocol checkers bind to, and it drives the slave-side handshake signals on all five channels. Write address and write data are accepted independently, in either order. Reads return registered data with a fixed one-cycle latency.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_AXI_ADDR_WIDTH, 8, byte address width.
NUM_REGS, 16, number of word registers; must be <= 2**(C_AXI_ADDR_WIDTH-2).

Ports:
AXI_ACLK  in  1  clock.
AXI_ARESET  in  1  synchronous reset, active-high.
AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address.
AXI_ARVALID  in  1  read address valid.
AXI_ARREADY  out  1  read address ready.
AXI_RDATA  out  C_AXI_DATA_WIDTH  read data.
AXI_RVALID  out  1  read data valid.
AXI_RREADY  in  1  read data ready.
AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address.
AXI_AWVALID  in  1  write address valid.
AXI_AWREADY  out  1  write address ready.
AXI_WDATA  in  C_AXI_DATA_WIDTH  write data.
AXI_WVALID  in  1  write data valid.
AXI_WREADY  out  1  write data ready.
AXI_BRESP  out  2  write response.
AXI_BVALID  out  1  write response valid.
AXI_BREADY  in  1  write response ready.

Behaviour:
- Interface: one clock, AXI_ACLK. Reset AXI_ARESET is synchronous and active-high.
- Reset: all registers cleared to 0. Internal flags aw_full, w_full cleared. RVALID=0, BVALID=0, RDATA=0, BRESP=00.
- Reset asserted mid-transaction aborts it. Pending address/data are discarded and no BVALID or RVALID follows.
- Decode: index = ADDR[C_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored. Out-of-range when index >= NUM_REGS.
- Write path, no FSM (three flags):
  - AWREADY = !aw_full && !BVALID.
  - WREADY = !w_full && !BVALID.
  - An AW handshake latches the address and sets aw_full. A W handshake latches the data and sets w_full.
  - In the cycle aw_full && w_full, the write commits. An in-range write updates the register. Flags clear, BVALID=1, BRESP is set.
  - BVALID and BRESP are held until BREADY; BVALID clears on the handshake edge.
  - New AW/W is accepted only after BVALID clears, so there is at most one outstanding write.
  - Latency: AW and W in the same cycle N -> commit edge N+1 -> BVALID visible in cycle N+2. Staggered arrival: BVALID two cycles after the later handshake.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA is registered from reg[index] (0 if out-of-range) and RVALID=1 the next cycle.
  - RDATA is held stable while RVALID && !RREADY.
  - RVALID clears on the RREADY handshake, and ARREADY rises the same cycle. Maximum throughput is one read per 2 cycles.
- Simultaneous events:
  - A read of a register committing a write on the same edge returns the OLD value.
  - Read and write channels operate fully concurrently.
- All outputs are registered or derived only from registered state. There are no combinational paths from inputs to outputs.
- AXI rule: VALID from the slave never drops before its READY.

Optional Feature:
AXIL_SLVERR_EN
- Defined: an out-of-range write returns BRESP=2'b10 (SLVERR).
- Undefined: BRESP is always 2'b00 (OKAY).
- In both cases the out-of-range write is dropped and no register changes.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - typedef axil_resp_t (logic [1:0]).
  - Function addr_to_index.
- Sub-module axil_reg_bank: NUM_REGS x 32 storage with one write port (we, index, data) and one registered read port. The top level holds the handshake logic.

Test Plan:
- AW=0x08 and W=0xDEADBEEF in the same cycle, BREADY=1 -> BVALID in cycle N+2 with BRESP=00; a following read of 0x08 returns 0xDEADBEEF one cycle after ARREADY.
- W=0x12345678 three cycles before AW=0x04 -> AWREADY stays high, WREADY low after capture; BVALID arrives 2 cycles after AW; read 0x04 returns 0x12345678.
- BREADY held low for 6 cycles after a write -> BVALID and BRESP stable; AWREADY and WREADY stay 0 throughout; a second write is accepted only after the B handshake.
- Write to 0x40 with NUM_REGS=16 -> BRESP=10 when AXIL_SLVERR_EN is defined, 00 when not; all 16 registers unchanged; read 0x40 returns 0.
- Read of 0x0C with RREADY low for 4 cycles -> RDATA stable; ARREADY=0 until the R handshake; read issued in the same edge as a write to 0x0C returns the old value.
- Assert AXI_ARESET while aw_full=1 and RVALID=1 -> next cycle RVALID=0, BVALID=0, AWREADY=1; no BVALID appears afterwards; a read of any register returns 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types, response codes and address decode helper for the AXI4-Lite register file.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    // Word index from a byte address; the two byte-lane bits are dropped.
    function automatic int unsigned addr_to_index(input logic [31:0] addr);
        return 32'(addr[31:2]);
    endfunction

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle (all five channels) with master and slave modports.
interface axil_slave_regfile_if #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8
);
    logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR;
    logic                        AXI_ARVALID;
    logic                        AXI_ARREADY;
    logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA;
    logic                        AXI_RVALID;
    logic                        AXI_RREADY;
    logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR;
    logic                        AXI_AWVALID;
    logic                        AXI_AWREADY;
    logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA;
    logic                        AXI_WVALID;
    logic                        AXI_WREADY;
    logic [1:0]                  AXI_BRESP;
    logic                        AXI_BVALID;
    logic                        AXI_BREADY;

    modport slave (
        input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
        output AXI_ARREADY, AXI_RDATA, AXI_RVALID,
        output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
    );

    modport master (
        output AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
        input  AXI_ARREADY, AXI_RDATA, AXI_RVALID,
        input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
    );

endinterface

// File: rtl/axil_reg_bank.sv
// NUM_REGS x DATA_W register storage: one write port, one registered read port.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [DATA_W-1:0] rd_mux;

    // Indices with no matching register fall through to zero, covering out-of-range reads.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_index == IDX_W'(i)) rd_mux = mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (we && wr_index == IDX_W'(i)) mem[i] <= wr_data;
            end
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file; handshake logic around axil_reg_bank.
// Optional macro AXIL_SLVERR_EN: out-of-range writes answer SLVERR instead of OKAY.
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS         = 16
) (
    input  logic                 AXI_ACLK,
    input  logic                 AXI_ARESET,
    axil_slave_regfile_if.slave  s_axi
);

    localparam int unsigned IDX_W = C_AXI_ADDR_WIDTH - 2;

    logic                        aw_full;
    logic                        w_full;
    logic [C_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [C_AXI_DATA_WIDTH-1:0] w_data;
    logic                        bvalid;
    axil_resp_t                  bresp;
    logic                        rvalid;

    logic        aw_hs, w_hs, ar_hs, commit, wr_in_range;
    int unsigned wr_idx;
    int unsigned rd_idx;

    assign s_axi.AXI_AWREADY = !aw_full && !bvalid;
    assign s_axi.AXI_WREADY  = !w_full && !bvalid;
    assign s_axi.AXI_BVALID  = bvalid;
    assign s_axi.AXI_BRESP   = bresp;
    assign s_axi.AXI_ARREADY = !rvalid;
    assign s_axi.AXI_RVALID  = rvalid;

    assign aw_hs  = s_axi.AXI_AWVALID && !aw_full && !bvalid;
    assign w_hs   = s_axi.AXI_WVALID && !w_full && !bvalid;
    assign ar_hs  = s_axi.AXI_ARVALID && !rvalid;
    assign commit = aw_full && w_full;

    assign wr_idx      = addr_to_index(32'(aw_addr));
    assign rd_idx      = addr_to_index(32'(s_axi.AXI_ARADDR));
    assign wr_in_range = wr_idx < NUM_REGS;

    // Handshakes cannot coincide with commit: both ready signals are low while both flags are set.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.AXI_AWADDR;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi.AXI_WDATA;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
`ifdef AXIL_SLVERR_EN
                bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
`else
                bresp   <= RESP_OKAY;
`endif
            end else if (bvalid && s_axi.AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            rvalid <= 1'b0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
        end else if (s_axi.AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    axil_reg_bank #(
        .DATA_W   (C_AXI_DATA_WIDTH),
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk      (AXI_ACLK),
        .rst      (AXI_ARESET),
        .we       (commit && wr_in_range),
        .wr_index (IDX_W'(wr_idx)),
        .wr_data  (w_data),
        .rd_en    (ar_hs),
        .rd_index (IDX_W'(rd_idx)),
        .rd_data  (s_axi.AXI_RDATA)
    );

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile: vector table plus hand sequences for timing corners.
module tb_axil_slave_regfile;

    logic clk;
    logic rst;
    int   total;
    int   bad;

`ifdef AXIL_SLVERR_EN
    localparam logic [31:0] OOR_RESP = 32'h2;
`else
    localparam logic [31:0] OOR_RESP = 32'h0;
`endif

    axil_slave_regfile_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) bus ();

    axil_slave_regfile #(
        .C_AXI_DATA_WIDTH (32),
        .C_AXI_ADDR_WIDTH (8),
        .NUM_REGS         (16)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESET (rst),
        .s_axi      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic write_txn(input logic [7:0] a, input logic [31:0] d,
                             output logic [1:0] resp, output bit tmo);
        bit aw_hs, w_hs;
        bus.AXI_AWADDR  = a;
        bus.AXI_WDATA   = d;
        bus.AXI_AWVALID = 1'b1;
        bus.AXI_WVALID  = 1'b1;
        bus.AXI_BREADY  = 1'b1;
        resp = 2'b00;
        tmo  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            aw_hs = bus.AXI_AWVALID && bus.AXI_AWREADY;
            w_hs  = bus.AXI_WVALID && bus.AXI_WREADY;
            cycle();
            if (aw_hs) bus.AXI_AWVALID = 1'b0;
            if (w_hs)  bus.AXI_WVALID  = 1'b0;
            if (bus.AXI_BVALID) begin
                resp = bus.AXI_BRESP;
                tmo  = 1'b0;
                cycle();
                break;
            end
        end
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
    endtask

    task automatic read_txn(input logic [7:0] a, output logic [31:0] d, output bit tmo);
        bus.AXI_ARADDR  = a;
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_RREADY  = 1'b1;
        d   = '0;
        tmo = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.AXI_ARREADY) begin
                cycle();
                bus.AXI_ARVALID = 1'b0;
                if (bus.AXI_RVALID) begin
                    d   = bus.AXI_RDATA;
                    tmo = 1'b0;
                end
                cycle();
                break;
            end
            cycle();
        end
        bus.AXI_ARVALID = 1'b0;
    endtask

    initial begin
        vec_t        vecs[13];
        logic [31:0] model[16];
        logic [1:0]  resp;
        logic [31:0] rd;
        bit          tmo;
        int          wait_n;

        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b1, 8'h00, 32'h1111_1111, 32'h0};
        vecs[1]  = '{1'b1, 8'h08, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b1, 8'h3C, 32'hA5A5_A5A5, 32'h0};
        vecs[3]  = '{1'b1, 8'h05, 32'hCAFE_F00D, 32'h0};
        vecs[4]  = '{1'b1, 8'h40, 32'hBADB_ADBA, OOR_RESP};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,         32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 8'h04, 32'h0,         32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 8'h3F, 32'h0,         32'hA5A5_A5A5};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,         32'h1111_1111};
        vecs[9]  = '{1'b0, 8'h40, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 8'hFC, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 8'h0B, 32'h0000_0001, 32'h0};
        vecs[12] = '{1'b0, 8'h08, 32'h0,         32'h0000_0001};

        for (int i = 0; i < 16; i++) model[i] = '0;

        rst             = 1'b1;
        bus.AXI_ARADDR  = '0;
        bus.AXI_ARVALID = 1'b0;
        bus.AXI_RREADY  = 1'b0;
        bus.AXI_AWADDR  = '0;
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WDATA   = '0;
        bus.AXI_WVALID  = 1'b0;
        bus.AXI_BREADY  = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;

        check("rst_awready", 32'(bus.AXI_AWREADY), 32'h1);
        check("rst_wready",  32'(bus.AXI_WREADY),  32'h1);
        check("rst_arready", 32'(bus.AXI_ARREADY), 32'h1);
        check("rst_rvalid",  32'(bus.AXI_RVALID),  32'h0);
        check("rst_bvalid",  32'(bus.AXI_BVALID),  32'h0);
        check("rst_rdata",   bus.AXI_RDATA,        32'h0);
        check("rst_bresp",   32'(bus.AXI_BRESP),   32'h0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                write_txn(vecs[i].addr, vecs[i].data, resp, tmo);
                check($sformatf("vec%0d_wr_tmo", i), 32'(tmo), 32'h0);
                check($sformatf("vec%0d_bresp", i), 32'(resp), vecs[i].exp);
                if (vecs[i].addr[7:6] == 2'b00) model[vecs[i].addr[5:2]] = vecs[i].data;
            end else begin
                read_txn(vecs[i].addr, rd, tmo);
                check($sformatf("vec%0d_rd_tmo", i), 32'(tmo), 32'h0);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
        end

        // Out-of-range write must leave every register untouched.
        for (int i = 0; i < 16; i++) begin
            read_txn(8'(i * 4), rd, tmo);
            check($sformatf("sweep_reg%0d", i), rd, model[i]);
        end

        // Same-cycle AW/W: BVALID two cycles after the handshake edge.
        bus.AXI_AWADDR  = 8'h10;
        bus.AXI_WDATA   = 32'h0BAD_F00D;
        bus.AXI_AWVALID = 1'b1;
        bus.AXI_WVALID  = 1'b1;
        bus.AXI_BREADY  = 1'b1;
        cycle();
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        check("lat_bvalid_n1", 32'(bus.AXI_BVALID), 32'h0);
        cycle();
        check("lat_bvalid_n2", 32'(bus.AXI_BVALID), 32'h1);
        check("lat_bresp",     32'(bus.AXI_BRESP),  32'h0);
        cycle();
        check("lat_bvalid_clr", 32'(bus.AXI_BVALID), 32'h0);

        // W three cycles ahead of AW.
        bus.AXI_WDATA  = 32'h1234_5678;
        bus.AXI_WVALID = 1'b1;
        cycle();
        bus.AXI_WVALID = 1'b0;
        check("stag_wready",  32'(bus.AXI_WREADY),  32'h0);
        check("stag_awready", 32'(bus.AXI_AWREADY), 32'h1);
        cycle();
        cycle();
        bus.AXI_AWADDR  = 8'h04;
        bus.AXI_AWVALID = 1'b1;
        cycle();
        bus.AXI_AWVALID = 1'b0;
        check("stag_bvalid_a1", 32'(bus.AXI_BVALID), 32'h0);
        cycle();
        check("stag_bvalid_a2", 32'(bus.AXI_BVALID), 32'h1);
        cycle();
        read_txn(8'h04, rd, tmo);
        check("stag_rdata", rd, 32'h1234_5678);

        // B backpressure with a second write waiting behind it.
        bus.AXI_BREADY  = 1'b0;
        bus.AXI_AWADDR  = 8'h20;
        bus.AXI_WDATA   = 32'h55AA_55AA;
        bus.AXI_AWVALID = 1'b1;
        bus.AXI_WVALID  = 1'b1;
        cycle();
        bus.AXI_AWADDR  = 8'h24;
        bus.AXI_WDATA   = 32'h0000_0077;
        wait_n = 0;
        while (!bus.AXI_BVALID && wait_n < 10) begin
            cycle();
            wait_n++;
        end
        check("bp_bvalid_seen", 32'(bus.AXI_BVALID), 32'h1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_bvalid_%0d", k),  32'(bus.AXI_BVALID),  32'h1);
            check($sformatf("bp_bresp_%0d", k),   32'(bus.AXI_BRESP),   32'h0);
            check($sformatf("bp_awready_%0d", k), 32'(bus.AXI_AWREADY), 32'h0);
            check($sformatf("bp_wready_%0d", k),  32'(bus.AXI_WREADY),  32'h0);
            cycle();
        end
        bus.AXI_BREADY = 1'b1;
        cycle();
        check("bp_bvalid_clr", 32'(bus.AXI_BVALID),  32'h0);
        check("bp_awready_up", 32'(bus.AXI_AWREADY), 32'h1);
        cycle();
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        wait_n = 0;
        while (!bus.AXI_BVALID && wait_n < 10) begin
            cycle();
            wait_n++;
        end
        check("bp_second_bvalid", 32'(bus.AXI_BVALID), 32'h1);
        cycle();
        read_txn(8'h20, rd, tmo);
        check("bp_first_data", rd, 32'h55AA_55AA);
        read_txn(8'h24, rd, tmo);
        check("bp_second_data", rd, 32'h0000_0077);

        // R backpressure: RDATA held, ARREADY low until the R handshake.
        write_txn(8'h0C, 32'h0C0C_0C0C, resp, tmo);
        check("rbp_wr_tmo", 32'(tmo), 32'h0);
        bus.AXI_ARADDR  = 8'h0C;
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_RREADY  = 1'b0;
        cycle();
        bus.AXI_ARVALID = 1'b0;
        check("rbp_rvalid", 32'(bus.AXI_RVALID), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rbp_rdata_%0d", k),   bus.AXI_RDATA,        32'h0C0C_0C0C);
            check($sformatf("rbp_arready_%0d", k), 32'(bus.AXI_ARREADY), 32'h0);
            cycle();
        end
        bus.AXI_RREADY = 1'b1;
        cycle();
        bus.AXI_RREADY = 1'b0;
        check("rbp_rvalid_clr", 32'(bus.AXI_RVALID),  32'h0);
        check("rbp_arready_up", 32'(bus.AXI_ARREADY), 32'h1);

        // AR handshake on the same edge as a write commit to that register sees the old value.
        bus.AXI_AWADDR  = 8'h0C;
        bus.AXI_WDATA   = 32'hFEED_FACE;
        bus.AXI_AWVALID = 1'b1;
        bus.AXI_WVALID  = 1'b1;
        bus.AXI_BREADY  = 1'b0;
        cycle();
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        bus.AXI_ARADDR  = 8'h0C;
        bus.AXI_ARVALID = 1'b1;
        cycle();
        bus.AXI_ARVALID = 1'b0;
        check("same_rvalid", 32'(bus.AXI_RVALID), 32'h1);
        check("same_bvalid", 32'(bus.AXI_BVALID), 32'h1);
        check("same_old",    bus.AXI_RDATA,       32'h0C0C_0C0C);
        bus.AXI_RREADY = 1'b1;
        bus.AXI_BREADY = 1'b1;
        cycle();
        read_txn(8'h0C, rd, tmo);
        check("same_new", rd, 32'hFEED_FACE);

        // Reset with a half-written address pending and read data outstanding.
        bus.AXI_RREADY  = 1'b0;
        bus.AXI_AWADDR  = 8'h10;
        bus.AXI_AWVALID = 1'b1;
        cycle();
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_ARADDR  = 8'h08;
        bus.AXI_ARVALID = 1'b1;
        cycle();
        bus.AXI_ARVALID = 1'b0;
        check("pre_rst_rvalid",  32'(bus.AXI_RVALID),  32'h1);
        check("pre_rst_awready", 32'(bus.AXI_AWREADY), 32'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_rvalid",  32'(bus.AXI_RVALID),  32'h0);
        check("mid_rst_bvalid",  32'(bus.AXI_BVALID),  32'h0);
        check("mid_rst_awready", 32'(bus.AXI_AWREADY), 32'h1);
        bus.AXI_WDATA  = 32'h9999_9999;
        bus.AXI_WVALID = 1'b1;
        cycle();
        bus.AXI_WVALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_rst_bvalid_%0d", k), 32'(bus.AXI_BVALID), 32'h0);
            cycle();
        end
        read_txn(8'h08, rd, tmo);
        check("post_rst_reg2",  rd, 32'h0);
        read_txn(8'h24, rd, tmo);
        check("post_rst_reg9",  rd, 32'h0);
        read_txn(8'h10, rd, tmo);
        check("post_rst_reg4",  rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
